// File: rtl/a5_1_stream_ctrl.sv
// a5_1_stream_ctrl: A5/1 majority-clocking controller that XORs pixel bytes with keystream bytes.
// Optional A51_KS_TAP_EN exposes the keystream byte alongside each result.
module a5_1_stream_ctrl #(
  parameter int WARMUP = 100,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [63:0]       key,
  output logic [18:0]       x_key,
  output logic [21:0]       y_key,
  output logic [22:0]       z_key,
  output logic              load,
  output logic              x_trig,
  output logic              y_trig,
  output logic              z_trig,
  input  logic              x_bit,
  input  logic              x_maj,
  input  logic              y_bit,
  input  logic              y_maj,
  input  logic              z_bit,
  input  logic              z_maj,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
`ifdef A51_KS_TAP_EN
  ,
  output logic [DATA_W-1:0] ks_byte,
  output logic              ks_valid
`endif
);
  localparam int CW = $clog2(WARMUP + DATA_W + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WARM, READY, GEN, OUT} state_t;
  state_t            state_q;
  logic [63:0]       key_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] data_q, ks_q, ks_d, out_data_q;
  logic              load_q, in_ready_q, out_valid_q, busy_q;
  logic              maj, step, ks_bit;
  assign maj    = (x_maj & y_maj) | (x_maj & z_maj) | (y_maj & z_maj);
  assign step   = (state_q == WARM) || (state_q == GEN);
  assign x_trig = step & (x_maj == maj);
  assign y_trig = step & (y_maj == maj);
  assign z_trig = step & (z_maj == maj);
  // keystream bit comes from the pre-step register state; first bit lands in the MSB
  assign ks_bit = x_bit ^ y_bit ^ z_bit;
  assign ks_d   = (ks_q << 1) | DATA_W'(ks_bit);
  assign x_key     = key_q[63:45];
  assign y_key     = key_q[44:23];
  assign z_key     = key_q[22:0];
  assign load      = load_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
`ifdef A51_KS_TAP_EN
  assign ks_byte  = ks_q;
  assign ks_valid = out_valid_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      ks_q        <= '0;
      out_data_q  <= '0;
      load_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          key_q   <= key;
          load_q  <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: begin
          load_q <= 1'b0;
          cnt_q  <= '0;
          if (WARMUP == 0) begin
            in_ready_q <= 1'b1;
            state_q    <= READY;
          end else state_q <= WARM;
        end
        WARM: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WARMUP - 1)) begin
            in_ready_q <= 1'b1;
            state_q    <= READY;
          end
        end
        READY: if (in_valid) begin
          data_q     <= in_data;
          cnt_q      <= '0;
          ks_q       <= '0;
          in_ready_q <= 1'b0;
          state_q    <= GEN;
        end
        GEN: begin
          ks_q  <= ks_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) begin
            out_data_q  <= data_q ^ ks_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= READY;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_a5_1_stream_ctrl.sv
// tb_a5_1_stream_ctrl: bench with attached A5/1 registers and an independent keystream model.
module tb_a5_1_stream_ctrl;
  localparam int WARMUP = 100;
  localparam int DW = 8;
  logic clk = 0, rst_n = 0, start = 0;
  logic [63:0] key = '0;
  logic [18:0] x_key;
  logic [21:0] y_key;
  logic [22:0] z_key;
  logic load, x_trig, y_trig, z_trig;
  logic x_bit, x_maj, y_bit, y_maj, z_bit, z_maj;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
  logic [DW-1:0] in_data = '0, out_data;
`ifdef A51_KS_TAP_EN
  logic [DW-1:0] ks_byte;
  logic ks_valid;
`endif
  logic [18:0] xr = '0;
  logic [21:0] yr = '0;
  logic [22:0] zr = '0;
  logic ov = 0, ovx = 0, ovy = 0, ovz = 0;
  logic [18:0] mx;
  logic [21:0] my;
  logic [22:0] mz;
  logic [DW-1:0] sbq[$];
  logic [DW-1:0] pt[4], c1[4];
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  assign x_bit = xr[18];
  assign y_bit = yr[21];
  assign z_bit = zr[22];
  assign x_maj = ov ? ovx : xr[8];
  assign y_maj = ov ? ovy : yr[10];
  assign z_maj = ov ? ovz : zr[10];

  always @(posedge clk) begin
    if (load) begin
      xr <= x_key;
      yr <= y_key;
      zr <= z_key;
    end else begin
      if (x_trig) xr <= {xr[17:0], xr[18] ^ xr[17] ^ xr[16] ^ xr[13]};
      if (y_trig) yr <= {yr[20:0], yr[21] ^ yr[20]};
      if (z_trig) zr <= {zr[21:0], zr[22] ^ zr[21] ^ zr[20] ^ zr[7]};
    end
  end

  a5_1_stream_ctrl #(.WARMUP(WARMUP), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key),
    .x_key(x_key), .y_key(y_key), .z_key(z_key), .load(load),
    .x_trig(x_trig), .y_trig(y_trig), .z_trig(z_trig),
    .x_bit(x_bit), .x_maj(x_maj), .y_bit(y_bit), .y_maj(y_maj), .z_bit(z_bit), .z_maj(z_maj),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef A51_KS_TAP_EN
    , .ks_byte(ks_byte), .ks_valid(ks_valid)
`endif
  );

  task automatic m_step(output bit b);
    bit m;
    b = mx[18] ^ my[21] ^ mz[22];
    m = (mx[8] & my[10]) | (mx[8] & mz[10]) | (my[10] & mz[10]);
    if (mx[8] == m) mx = {mx[17:0], mx[18] ^ mx[17] ^ mx[16] ^ mx[13]};
    if (my[10] == m) my = {my[20:0], my[21] ^ my[20]};
    if (mz[10] == m) mz = {mz[21:0], mz[22] ^ mz[21] ^ mz[20] ^ mz[7]};
  endtask

  task automatic m_load(input logic [63:0] k);
    bit b;
    mx = k[63:45];
    my = k[44:23];
    mz = k[22:0];
    repeat (WARMUP) m_step(b);
  endtask

  task automatic m_byte(output logic [DW-1:0] ks);
    bit b;
    ks = '0;
    for (int i = 0; i < DW; i++) begin
      m_step(b);
      ks = {ks[DW-2:0], b};
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; start = 0; in_valid = 0; out_ready = 0; ov = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    sbq.delete();
  endtask

  task automatic session(input logic [63:0] k);
    int n = 0;
    @(negedge clk);
    key = k;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    m_load(k);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    nchk++;
    if (!in_ready) begin
      nerr++;
      $display("FAIL session_ready: in_ready=%b required 1 after %0d cycles", in_ready, n);
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    logic [DW-1:0] ks;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    nchk++;
    if (!in_ready) begin
      nerr++;
      $display("FAIL send_wait: in_ready=%b required 1", in_ready);
      return;
    end
    in_valid = 1;
    in_data = d;
    @(posedge clk);
    #1 in_valid = 0;
    m_byte(ks);
    sbq.push_back(d ^ ks);
  endtask

  task automatic recv(output logic [DW-1:0] got);
    int n = 0;
    logic [DW-1:0] exp;
    got = 'x;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    nchk++;
    if (!out_valid || sbq.size() == 0) begin
      nerr++;
      $display("FAIL recv_wait: out_valid=%b queued=%0d required valid with entry", out_valid, sbq.size());
      return;
    end
    exp = sbq.pop_front();
    got = out_data;
    nchk++;
    if (out_data !== exp) begin
      nerr++;
      $display("FAIL scoreboard: out_data=%h required %h", out_data, exp);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    nchk++;
    if ({load, x_trig, y_trig, z_trig, in_ready, out_valid, busy} !== 7'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: ctrl=%b required 0", {load, x_trig, y_trig, z_trig, in_ready, out_valid, busy});
    end
    nchk++;
    if ({out_data, x_key, y_key, z_key} !== '0) begin
      nerr++;
      $display("FAIL reset_data: out_data=%h keys=%h/%h/%h required 0", out_data, x_key, y_key, z_key);
    end
    do_reset();
  endtask

  task automatic test_timing(input logic [63:0] k);
    logic [DW-1:0] got;
    @(negedge clk);
    key = k;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    m_load(k);
    for (int c = 1; c <= WARMUP + 2; c++) begin
      @(negedge clk);
      nchk++;
      if (load !== (c == 1)) begin
        nerr++;
        $display("FAIL timing_load: cycle %0d load=%b required %b", c, load, c == 1);
      end
      nchk++;
      if ((x_trig | y_trig | z_trig) !== (c >= 2 && c <= WARMUP + 1)) begin
        nerr++;
        $display("FAIL timing_trig: cycle %0d trig=%b%b%b", c, x_trig, y_trig, z_trig);
      end
      nchk++;
      if (in_ready !== (c == WARMUP + 2)) begin
        nerr++;
        $display("FAIL timing_ready: cycle %0d in_ready=%b required %b", c, in_ready, c == WARMUP + 2);
      end
      if (c == 1) begin
        nchk++;
        if ({x_key, y_key, z_key} !== k) begin
          nerr++;
          $display("FAIL timing_keys: keys=%h required %h", {x_key, y_key, z_key}, k);
        end
      end
      if (c >= 2 && c <= WARMUP + 1) begin
        nchk++;
        if (int'(x_trig) + int'(y_trig) + int'(z_trig) < 2) begin
          nerr++;
          $display("FAIL timing_maj: cycle %0d trig=%b%b%b required >=2 high", c, x_trig, y_trig, z_trig);
        end
      end
    end
    send(8'h3C);
    for (int c = 1; c <= DW + 1; c++) begin
      @(negedge clk);
      nchk++;
      if (out_valid !== (c == DW + 1) || (x_trig | y_trig | z_trig) !== (c <= DW)) begin
        nerr++;
        $display("FAIL latency: t+%0d out_valid=%b trig=%b%b%b", c, out_valid, x_trig, y_trig, z_trig);
      end
    end
    recv(got);
    @(negedge clk);
    nchk++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL throughput: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_zero_key();
    logic [DW-1:0] got;
    do_reset();
    session(64'h0);
    send(8'hA5);
    recv(got);
    nchk++;
    if (got !== 8'hA5) begin
      nerr++;
      $display("FAIL zero_key: out_data=%h required a5", got);
    end
  endtask

  task automatic test_known_answer(input logic [63:0] k);
    logic [DW-1:0] got;
    pt[0] = 8'h00; pt[1] = 8'h00; pt[2] = 8'h3C; pt[3] = 8'hFF;
    do_reset();
    session(k);
    for (int i = 0; i < 4; i++) begin
      send(pt[i]);
      recv(c1[i]);
    end
    do_reset();
    session(k);
    for (int i = 0; i < 4; i++) begin
      send(pt[i]);
      recv(got);
      nchk++;
      if (got !== c1[i]) begin
        nerr++;
        $display("FAIL repeat_run: byte %0d out_data=%h required %h", i, got, c1[i]);
      end
    end
    do_reset();
    session(k);
    for (int i = 0; i < 4; i++) begin
      send(c1[i]);
      recv(got);
      nchk++;
      if (got !== pt[i]) begin
        nerr++;
        $display("FAIL decrypt: byte %0d out_data=%h required %h", i, got, pt[i]);
      end
    end
  endtask

  task automatic test_backpressure(input logic [63:0] k);
    logic [DW-1:0] got;
    int n = 0;
    do_reset();
    session(k);
    send(pt[0]);
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nchk++;
      if (out_valid !== 1'b1 || sbq.size() == 0 || out_data !== sbq[0] || (x_trig | y_trig | z_trig) !== 1'b0) begin
        nerr++;
        $display("FAIL stall: cycle %0d out_valid=%b out_data=%h trig=%b%b%b", c, out_valid, out_data, x_trig, y_trig, z_trig);
      end
    end
    recv(got);
    repeat (15) begin
      @(negedge clk);
      nchk++;
      if ((x_trig | y_trig | z_trig) !== 1'b0) begin
        nerr++;
        $display("FAIL ready_idle: trig=%b%b%b required 000", x_trig, y_trig, z_trig);
      end
    end
    send(pt[1]);
    recv(got);
    nchk++;
    if (got !== c1[1]) begin
      nerr++;
      $display("FAIL after_stall: out_data=%h required %h", got, c1[1]);
    end
  endtask

  task automatic test_tap();
    do_reset();
    @(negedge clk);
    key = 64'h0123_4567_89AB_CDEF;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (5) @(negedge clk);
    ov = 1; ovx = 1; ovy = 0; ovz = 1;
    #1 nchk++;
    if ({x_trig, y_trig, z_trig} !== 3'b101) begin
      nerr++;
      $display("FAIL tap_101: trig=%b%b%b required 101", x_trig, y_trig, z_trig);
    end
    ovx = 0; ovz = 0;
    #1 nchk++;
    if ({x_trig, y_trig, z_trig} !== 3'b111) begin
      nerr++;
      $display("FAIL tap_000: trig=%b%b%b required 111", x_trig, y_trig, z_trig);
    end
    ovy = 1; ovz = 1;
    #1 nchk++;
    if ({x_trig, y_trig, z_trig} !== 3'b011) begin
      nerr++;
      $display("FAIL tap_011: trig=%b%b%b required 011", x_trig, y_trig, z_trig);
    end
    ov = 0;
  endtask

  task automatic test_mid_reset(input logic [63:0] k);
    logic [DW-1:0] got;
    do_reset();
    session(k);
    send(8'h5A);
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1 nchk++;
    if ({load, x_trig, y_trig, z_trig, in_ready, out_valid, busy, out_data} !== '0) begin
      nerr++;
      $display("FAIL mid_reset: ctrl=%b out_data=%h required 0", {load, x_trig, y_trig, z_trig, in_ready, out_valid, busy}, out_data);
    end
    @(negedge clk);
    rst_n = 1;
    sbq.delete();
    repeat (3) begin
      @(negedge clk);
      nchk++;
      if ({busy, in_ready, load} !== 3'b0) begin
        nerr++;
        $display("FAIL post_reset_idle: busy=%b in_ready=%b load=%b required 0", busy, in_ready, load);
      end
    end
    session(k);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (3) begin
      @(negedge clk);
      nchk++;
      if (load !== 1'b0 || in_ready !== 1'b1) begin
        nerr++;
        $display("FAIL start_ignored: load=%b in_ready=%b required 0/1", load, in_ready);
      end
    end
    send(pt[0]);
    recv(got);
    nchk++;
    if (got !== c1[0]) begin
      nerr++;
      $display("FAIL start_ignored_data: out_data=%h required %h", got, c1[0]);
    end
  endtask

  initial begin
    test_reset();
    test_timing(64'hDEAD_BEEF_0BAD_F00D);
    test_zero_key();
    test_known_answer(64'h1234_5678_9ABC_DEF0);
    test_backpressure(64'h1234_5678_9ABC_DEF0);
    test_tap();
    test_mid_reset(64'h1234_5678_9ABC_DEF0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", nchk, nerr);
    $fatal(1);
  end
endmodule
